// File: rtl/gain_ramp_if.sv
// Stream bundle for the gain_ramp datapath: sample in, scaled sample out,
// plus the target-gain write port. master drives the design, slave is the design.
interface gain_ramp_if #(
    parameter int FXP_SIZE = 16,
    parameter int CHW      = 1
);
    logic                i_valid;
    logic                o_ready;
    logic [FXP_SIZE-1:0] i_sample;
    logic [CHW-1:0]      i_channel;
    logic                i_bypass;
    logic                i_gain_we;
    logic [CHW-1:0]      i_gain_ch;
    logic [FXP_SIZE-1:0] i_gain_target;
    logic                o_valid;
    logic                i_ready;
    logic [FXP_SIZE-1:0] o_sample;
    logic [CHW-1:0]      o_channel;
    logic                o_clip;

    modport master (
        output i_valid, i_sample, i_channel, i_bypass,
        output i_gain_we, i_gain_ch, i_gain_target, i_ready,
        input  o_ready, o_valid, o_sample, o_channel, o_clip
    );

    modport slave (
        input  i_valid, i_sample, i_channel, i_bypass,
        input  i_gain_we, i_gain_ch, i_gain_target, i_ready,
        output o_ready, o_valid, o_sample, o_channel, o_clip
    );
endinterface

// File: rtl/gain_ramp.sv
// Per-channel ramped gain: 2-stage multiply then round/saturate pipeline.
// Ports: i_clk/i_rst_n, sample in (valid/ready), target write, sample out (valid/ready).
module gain_ramp #(
    parameter int FXP_SIZE       = 16,
    parameter int BITS_PER_LEVEL = 12,
    parameter int CHANNELS       = 2,
    parameter int RAMP_STEP      = 16,
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [FXP_SIZE-1:0] i_sample,
    input  logic [CHW-1:0]      i_channel,
    input  logic                i_bypass,
    input  logic                i_gain_we,
    input  logic [CHW-1:0]      i_gain_ch,
    input  logic [FXP_SIZE-1:0] i_gain_target,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [FXP_SIZE-1:0] o_sample,
    output logic [CHW-1:0]      o_channel,
    output logic                o_clip
);
    localparam int PW = 2 * FXP_SIZE + 2;
    localparam logic [FXP_SIZE-1:0] UNITY =
        {{(FXP_SIZE-1){1'b0}}, 1'b1} << BITS_PER_LEVEL;
    localparam logic [FXP_SIZE-1:0] STEP = FXP_SIZE'(RAMP_STEP);
    localparam logic signed [PW-1:0] RND =
        {{(PW-1){1'b0}}, 1'b1} << (BITS_PER_LEVEL - 1);

    logic [FXP_SIZE-1:0] cur_q [CHANNELS];
    logic [FXP_SIZE-1:0] cur_d [CHANNELS];
    logic [FXP_SIZE-1:0] tgt_q [CHANNELS];
    logic [FXP_SIZE-1:0] tgt_d [CHANNELS];

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_bypass_q, s1_bypass_d;
    logic [FXP_SIZE-1:0]  s1_sample_q, s1_sample_d;
    logic [CHW-1:0]       s1_channel_q, s1_channel_d;
    logic signed [PW-1:0] s1_prod_q, s1_prod_d;

    logic                o_valid_q, o_valid_d;
    logic [FXP_SIZE-1:0] o_sample_q, o_sample_d;
    logic [CHW-1:0]      o_channel_q, o_channel_d;
    logic                o_clip_q, o_clip_d;

    logic                    accept;
    logic [FXP_SIZE-1:0]     gain;
    logic signed [FXP_SIZE:0] g_ext;
    logic signed [FXP_SIZE:0] s_ext;
    logic signed [PW-1:0]    sum;
    logic signed [PW-1:0]    sh;
    logic                    fits;
    logic [FXP_SIZE-1:0]     sat;

    function automatic logic [FXP_SIZE-1:0] ramp_to(
        input logic [FXP_SIZE-1:0] cur,
        input logic [FXP_SIZE-1:0] tgt
    );
        logic [FXP_SIZE-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return cur + ((diff > STEP) ? STEP : diff);
        end else if (cur > tgt) begin
            diff = cur - tgt;
            return cur - ((diff > STEP) ? STEP : diff);
        end
        return cur;
    endfunction

    assign o_ready = !o_valid_q || i_ready;
    assign accept  = i_valid && o_ready;

    // Ramp uses the old target, so a same-cycle write takes effect next sample.
    // Out-of-range channels match no entry: gain stays 0, no state moves.
    always_comb begin
        gain  = '0;
        cur_d = cur_q;
        tgt_d = tgt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_gain_we && i_gain_ch == CHW'(c)) begin
                tgt_d[c] = i_gain_target;
            end
            if (i_channel == CHW'(c)) begin
                gain = cur_q[c];
                if (accept) begin
                    cur_d[c] = ramp_to(cur_q[c], tgt_q[c]);
                end
            end
        end
    end

    assign g_ext = signed'({1'b0, gain});
    assign s_ext = signed'({i_sample[FXP_SIZE-1], i_sample});

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_bypass_d  = s1_bypass_q;
        s1_sample_d  = s1_sample_q;
        s1_channel_d = s1_channel_q;
        s1_prod_d    = s1_prod_q;
        if (o_ready) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_bypass_d  = i_bypass;
                s1_sample_d  = i_sample;
                s1_channel_d = i_channel;
                s1_prod_d    = PW'(g_ext) * PW'(s_ext);
            end
        end
    end

    // Round half toward +inf, then clamp if the upper bits are not all sign.
    assign sum  = s1_prod_q + RND;
    assign sh   = sum >>> BITS_PER_LEVEL;
    assign fits = (&sh[PW-1:FXP_SIZE-1]) || !(|sh[PW-1:FXP_SIZE-1]);
    assign sat  = sh[PW-1] ? {1'b1, {(FXP_SIZE-1){1'b0}}}
                           : {1'b0, {(FXP_SIZE-1){1'b1}}};

    always_comb begin
        o_valid_d   = o_valid_q;
        o_sample_d  = o_sample_q;
        o_channel_d = o_channel_q;
        o_clip_d    = o_clip_q;
        if (o_ready) begin
            o_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_channel_d = s1_channel_q;
                if (s1_bypass_q) begin
                    o_sample_d = s1_sample_q;
                    o_clip_d   = 1'b0;
                end else begin
                    o_sample_d = fits ? sh[FXP_SIZE-1:0] : sat;
                    o_clip_d   = !fits;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cur_q[c] <= UNITY;
                tgt_q[c] <= UNITY;
            end
            s1_valid_q   <= 1'b0;
            s1_bypass_q  <= 1'b0;
            s1_sample_q  <= '0;
            s1_channel_q <= '0;
            s1_prod_q    <= '0;
            o_valid_q    <= 1'b0;
            o_sample_q   <= '0;
            o_channel_q  <= '0;
            o_clip_q     <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                cur_q[c] <= cur_d[c];
                tgt_q[c] <= tgt_d[c];
            end
            s1_valid_q   <= s1_valid_d;
            s1_bypass_q  <= s1_bypass_d;
            s1_sample_q  <= s1_sample_d;
            s1_channel_q <= s1_channel_d;
            s1_prod_q    <= s1_prod_d;
            o_valid_q    <= o_valid_d;
            o_sample_q   <= o_sample_d;
            o_channel_q  <= o_channel_d;
            o_clip_q     <= o_clip_d;
        end
    end

    assign o_valid   = o_valid_q;
    assign o_sample  = o_sample_q;
    assign o_channel = o_channel_q;
    assign o_clip    = o_clip_q;
endmodule
